// File: rtl/sdfm_comp_sched.sv
// Round-robin scheduler that funnels NCH comparator channels onto one valid/ready record stream,
// with per-channel sticky low/high/overrun flags and a registered level interrupt.
module sdfm_comp_sched #(
   parameter int NCH = 4,
   parameter int DW  = 32,
   parameter int CW  = 2
) (
   input  logic                SYSCLK,
   input  logic                SYSRSTn,
   input  logic [NCH-1:0]      ch_en,
   input  logic [NCH-1:0]      ch_update,
   input  logic [NCH*DW-1:0]   ch_data,
   input  logic [NCH-1:0]      ch_low,
   input  logic [NCH-1:0]      ch_high,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       out_data,
   output logic [CW-1:0]       out_ch,
   output logic                out_low,
   output logic                out_high,
   input  logic [NCH-1:0]      ilen,
   input  logic [NCH-1:0]      ihen,
   input  logic [NCH-1:0]      flg_clr,
   output logic [NCH-1:0]      flg_low,
   output logic [NCH-1:0]      flg_high,
   output logic [NCH-1:0]      flg_ovf,
   output logic                irq
);

   // Output handshake: a record transfers on a rising edge where out_valid & out_ready;
   // out_* are held stable from the cycle out_valid rises until that transfer.
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [NCH-1:0]    pend_q, pend_d;
   logic [DW-1:0]     hold_data_q [NCH];
   logic [DW-1:0]     hold_data_d [NCH];
   logic [NCH-1:0]    hold_low_q, hold_low_d;
   logic [NCH-1:0]    hold_high_q, hold_high_d;
   logic [CW-1:0]     last_q, last_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [CW-1:0]     out_ch_q, out_ch_d;
   logic              out_low_q, out_low_d;
   logic              out_high_q, out_high_d;
   logic [NCH-1:0]    flg_low_q, flg_low_d;
   logic [NCH-1:0]    flg_high_q, flg_high_d;
   logic [NCH-1:0]    flg_ovf_q, flg_ovf_d;
   logic              irq_q, irq_d;

   logic [NCH-1:0]    cap;
   logic [NCH-1:0]    gnt_oh;
   logic [CW-1:0]     gnt_idx;
   logic [CW-1:0]     cand;
   logic              found;
   logic              do_grant;

   // Search last+1 .. last+NCH (mod NCH); the first pending channel wins.
   always_comb begin
      gnt_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         cand = CW'((int'(last_q) + k) % NCH);
         if (!found && pend_q[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      do_grant = found && ((state_q == ST_IDLE) || (out_valid_q && out_ready));
      for (int i = 0; i < NCH; i++) begin
         gnt_oh[i] = do_grant && (gnt_idx == CW'(i));
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_low_d   = out_low_q;
      out_high_d  = out_high_q;

      if (do_grant) begin
         out_valid_d = 1'b1;
         out_data_d  = hold_data_q[gnt_idx];
         out_ch_d    = gnt_idx;
         out_low_d   = hold_low_q[gnt_idx];
         out_high_d  = hold_high_q[gnt_idx];
         last_d      = gnt_idx;
         state_d     = ST_BUSY;
      end else if ((state_q == ST_BUSY) && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ST_IDLE;
      end

      for (int i = 0; i < NCH; i++) begin
         cap[i]         = ch_update[i] & ch_en[i];
         hold_data_d[i] = cap[i] ? ch_data[i*DW +: DW] : hold_data_q[i];
         hold_low_d[i]  = cap[i] ? ch_low[i]  : hold_low_q[i];
         hold_high_d[i] = cap[i] ? ch_high[i] : hold_high_q[i];

         // A capture on the channel being granted refills pend instead of overrunning it.
         if (!ch_en[i])       pend_d[i] = 1'b0;
         else if (cap[i])     pend_d[i] = 1'b1;
         else if (gnt_oh[i])  pend_d[i] = 1'b0;
         else                 pend_d[i] = pend_q[i];

         flg_low_d[i]  = (cap[i] & ch_low[i])  | (flg_low_q[i]  & ~flg_clr[i]);
         flg_high_d[i] = (cap[i] & ch_high[i]) | (flg_high_q[i] & ~flg_clr[i]);
         flg_ovf_d[i]  = (cap[i] & pend_q[i] & ~gnt_oh[i]) | (flg_ovf_q[i] & ~flg_clr[i]);
      end

      irq_d = |((flg_low_q & ilen) | (flg_high_q & ihen) | flg_ovf_q);
   end

   always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
      if (!SYSRSTn) begin
         state_q     <= ST_IDLE;
         pend_q      <= '0;
         for (int i = 0; i < NCH; i++) begin
            hold_data_q[i] <= '0;
         end
         hold_low_q  <= '0;
         hold_high_q <= '0;
         last_q      <= CW'(NCH - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_low_q   <= 1'b0;
         out_high_q  <= 1'b0;
         flg_low_q   <= '0;
         flg_high_q  <= '0;
         flg_ovf_q   <= '0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         hold_data_q <= hold_data_d;
         hold_low_q  <= hold_low_d;
         hold_high_q <= hold_high_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_low_q   <= out_low_d;
         out_high_q  <= out_high_d;
         flg_low_q   <= flg_low_d;
         flg_high_q  <= flg_high_d;
         flg_ovf_q   <= flg_ovf_d;
         irq_q       <= irq_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_low   = out_low_q;
   assign out_high  = out_high_q;
   assign flg_low   = flg_low_q;
   assign flg_high  = flg_high_q;
   assign flg_ovf   = flg_ovf_q;
   assign irq       = irq_q;

endmodule
